// File: rtl/ascii_symbol_sequencer.sv
// ASCII '0'..'3' to 2-bit symbol framer with line-terminator release,
// valid/ready frame handoff and one-cycle error pulses.
module ascii_symbol_sequencer #(
    parameter int N_SYMBOLS      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [6:0]                           rx_data,
    input  logic                                 rx_valid,
    input  logic                                 clear,
    output logic [2*N_SYMBOLS-1:0]               frame_data,
    output logic                                 frame_valid,
    input  logic                                 frame_ready,
    output logic [$clog2(N_SYMBOLS+1)-1:0]       symbol_count,
    output logic                                 busy,
    output logic                                 err_char,
    output logic                                 err_len,
    output logic                                 err_timeout
);

    localparam int CW = $clog2(N_SYMBOLS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(N_SYMBOLS);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t                 state_q;
    logic [2*N_SYMBOLS-1:0] frame_q;
    logic [2*N_SYMBOLS-1:0] frame_d;
    logic [CW-1:0]          count_q;
    logic [TW-1:0]          timer_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   err_char_q;
    logic                   err_len_q;
    logic                   err_to_q;

    logic       is_digit;
    logic       is_term;
    logic [1:0] sym;
    logic       full;
    logic       expired;

    assign is_digit = (rx_data[6:2] == 5'b01100);
    assign is_term  = (rx_data == 7'h0A) || (rx_data == 7'h0D);
    assign sym      = rx_data[1:0];
    assign full     = (count_q == FULL);
    assign expired  = (timer_q == TMAX);

    // Frame image with the incoming symbol dropped into slot count_q.
    always_comb begin
        frame_d = frame_q;
        for (int i = 0; i < N_SYMBOLS; i++) begin
            if (count_q == CW'(i)) begin
                frame_d[2*i +: 2] = sym;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_char_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            err_char_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                frame_q <= '0;
                count_q <= '0;
                timer_q <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_valid) begin
                            if (is_digit) begin
                                frame_q[1:0] <= sym;
                                count_q      <= CW'(1);
                                timer_q      <= '0;
                                state_q      <= S_COLLECT;
                                busy_q       <= 1'b1;
                            end else if (!is_term) begin
                                err_char_q <= 1'b1;
                                timer_q    <= '0;
                                state_q    <= S_DISCARD;
                                busy_q     <= 1'b1;
                            end
                        end
                    end
                    S_COLLECT: begin
                        if (rx_valid) begin
                            timer_q <= '0;
                            if (is_digit) begin
                                if (full) begin
                                    err_len_q <= 1'b1;
                                    state_q   <= S_DISCARD;
                                end else begin
                                    frame_q <= frame_d;
                                    count_q <= count_q + CW'(1);
                                end
                            end else if (is_term) begin
                                if (full) begin
                                    valid_q <= 1'b1;
                                    state_q <= S_HOLD;
                                end else begin
                                    err_len_q <= 1'b1;
                                    count_q   <= '0;
                                    state_q   <= S_IDLE;
                                    busy_q    <= 1'b0;
                                end
                            end else begin
                                err_char_q <= 1'b1;
                                state_q    <= S_DISCARD;
                            end
                        end else if (expired) begin
                            err_to_q <= 1'b1;
                            count_q  <= '0;
                            timer_q  <= '0;
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_DISCARD: begin
                        if (rx_valid) begin
                            timer_q <= '0;
                            if (is_term) begin
                                count_q <= '0;
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else if (expired) begin
                            count_q <= '0;
                            timer_q <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_HOLD: begin
                        // Bytes arriving here are dropped; busy throttles upstream.
                        if (frame_ready) begin
                            valid_q <= 1'b0;
                            count_q <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign frame_data   = frame_q;
    assign frame_valid  = valid_q;
    assign symbol_count = count_q;
    assign busy         = busy_q;
    assign err_char     = err_char_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_to_q;

    a_one_err: assert property (
        @(posedge clock) disable iff (!reset_n)
        $onehot0({err_char_q, err_len_q, err_to_q})
    );

    a_valid_busy: assert property (
        @(posedge clock) disable iff (!reset_n)
        valid_q |-> busy_q
    );

endmodule

// File: tb/tb_ascii_symbol_sequencer.sv
// Scoreboard bench: line-level reference model predicts frames/errors,
// a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_ascii_symbol_sequencer;

    localparam int N = 4;
    localparam int T = 16;
    localparam int K_FRAME = 0;
    localparam int K_CHAR  = 1;
    localparam int K_LEN   = 2;
    localparam int K_TO    = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       clear = 1'b0;
    logic       frame_ready = 1'b0;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic [2:0] symbol_count;
    logic       busy;
    logic       err_char;
    logic       err_len;
    logic       err_timeout;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    ascii_symbol_sequencer #(
        .N_SYMBOLS(N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .clear(clear),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .symbol_count(symbol_count),
        .busy(busy),
        .err_char(err_char),
        .err_len(err_len),
        .err_timeout(err_timeout)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  line[$];
    bit  discarding;
    bit  holding;
    int  gap;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, req, cyc);
        end
    endfunction

    function automatic void push(int k, logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endfunction

    function automatic logic [7:0] pack();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < line.size(); i++) begin
            v = v | (8'(line[i]) << (2 * i));
        end
        return v;
    endfunction

    task automatic model_byte(input logic [6:0] b);
        bit dig;
        bit term;
        dig  = (b >= 7'h30) && (b <= 7'h33);
        term = (b == 7'h0A) || (b == 7'h0D);
        if (discarding) begin
            if (term) begin
                discarding = 0;
                line.delete();
            end
        end else if (dig) begin
            if (line.size() == N) begin
                push(K_LEN, 0);
                discarding = 1;
            end else begin
                line.push_back(int'(b) - 48);
            end
        end else if (term) begin
            if (line.size() == N) begin
                push(K_FRAME, pack());
                holding = 1;
            end else if (line.size() > 0) begin
                push(K_LEN, 0);
                line.delete();
            end
        end else begin
            push(K_CHAR, 0);
            discarding = 1;
        end
    endtask

    // Reference model: advances once per clock from the driven inputs.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            line.delete();
            exp_q.delete();
            discarding = 0;
            holding = 0;
            gap = 0;
        end else begin
            cyc++;
            if (clear) begin
                line.delete();
                discarding = 0;
                holding = 0;
                gap = 0;
            end else if (holding) begin
                if (frame_ready) begin
                    holding = 0;
                    line.delete();
                end
            end else if (rx_valid) begin
                gap = 0;
                model_byte(rx_data);
            end else if (discarding || line.size() > 0) begin
                gap++;
                if (gap == T) begin
                    if (!discarding) push(K_TO, 0);
                    line.delete();
                    discarding = 0;
                    gap = 0;
                end
            end
        end
    end

    int         nerr;
    int         kind;
    ev_t        e;
    bit         fv_prev;
    logic [7:0] fd_prev;
    int         last_to = -1;

    always @(negedge clock) begin
        if (!reset_n) begin
            fv_prev = 0;
        end else begin
            nerr = int'(err_char) + int'(err_len) + int'(err_timeout);
            chk("frame_valid", frame_valid, holding);
            chk("busy", busy, holding || discarding || line.size() > 0);
            chk("symbol_count", symbol_count, line.size());
            if (nerr > 1) chk("one_err", nerr, 1);
            if (nerr == 1 || (frame_valid && !fv_prev)) begin
                kind = err_char ? K_CHAR : err_len ? K_LEN :
                       err_timeout ? K_TO : K_FRAME;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got kind %0d expected none at cyc %0d",
                             kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_cyc", cyc, e.cyc);
                    if (kind == K_FRAME) chk("ev_data", frame_data, e.data);
                end
            end
            if (frame_valid && fv_prev) chk("fd_stable", frame_data, fd_prev);
            if (err_timeout) last_to = cyc;
            fv_prev = frame_valid;
            fd_prev = frame_data;
        end
    end

    task automatic drive(input bit v, input logic [6:0] d, input bit rdy, input bit clr);
        @(negedge clock);
        rx_valid    = v;
        rx_data     = d;
        frame_ready = rdy;
        clear       = clr;
    endtask

    task automatic send(input logic [6:0] b, input bit rdy = 0);
        drive(1, b, rdy, 0);
    endtask

    task automatic idle(input int n, input bit rdy = 0);
        repeat (n) drive(0, 7'h00, rdy, 0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(7'(s[i]));
    endtask

    logic [7:0] held;
    int         t0;
    int         len;
    int         g;
    logic [6:0] c;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fd", frame_data, 0);
        chk("rst_cnt", symbol_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", {err_char, err_len, err_timeout}, 0);
        reset_n = 1'b1;
        idle(2);

        send_str("3021");
        send(7'h0A);
        idle(5);
        chk("good_fv", frame_valid, 1);
        chk("good_fd", frame_data, 8'b01_10_00_11);
        drive(0, 0, 1, 0);
        idle(1);
        chk("good_idle_busy", busy, 0);
        chk("good_idle_cnt", symbol_count, 0);

        send_str("12");
        send(7'h0D);
        idle(3);
        send_str("00000");
        send(7'h0A);
        idle(3);

        send_str("1A2");
        send(7'h0A);
        send_str("2222");
        send(7'h0A);
        idle(1);
        chk("illegal_then_aa", frame_data, 8'hAA);
        drive(0, 0, 1, 0);
        idle(2);

        send(7'h33);
        t0 = cyc;
        idle(20);
        chk("timeout_cyc", last_to, t0 + 17);
        chk("timeout_busy", busy, 0);

        send_str("1");
        idle(14);
        send_str("2");
        idle(14);
        send_str("0");
        idle(14);
        send_str("3");
        idle(14);
        send(7'h0A);
        idle(1);
        chk("slow_line_fd", frame_data, 8'b11_00_10_01);
        drive(0, 0, 1, 0);
        idle(2);

        send_str("2130");
        send(7'h0A);
        idle(1);
        held = frame_data;
        send_str("1111");
        send(7'h0A);
        chk("hold_fd", frame_data, held);
        send(7'h31, 1);
        idle(1);
        chk("hold_drop_cnt", symbol_count, 0);
        chk("hold_drop_busy", busy, 0);

        send_str("12");
        drive(1, 7'h33, 0, 1);
        idle(1);
        chk("clear_cnt", symbol_count, 0);
        chk("clear_fd", frame_data, 0);
        chk("clear_busy", busy, 0);

        send_str("3333");
        send(7'h0A);
        idle(1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_fv", frame_valid, 0);
        chk("arst_fd", frame_data, 0);
        chk("arst_busy", busy, 0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        for (int n = 0; n < 300; n++) begin
            len = $urandom_range(0, 6);
            for (int i = 0; i <= len; i++) begin
                if (i == len) c = ($urandom_range(0, 1) == 0) ? 7'h0A : 7'h0D;
                else if ($urandom_range(0, 19) == 0) c = 7'($urandom_range(0, 127));
                else c = 7'h30 + 7'($urandom_range(0, 3));
                drive(1, c, $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
                g = ($urandom_range(0, 24) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 2);
                for (int j = 0; j < g; j++) drive(0, 0, $urandom_range(0, 2) == 0, 0);
            end
        end
        idle(T + 5, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
